display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter_pkg.sv | 23 ++
 rtl/display_arbiter_rr_picker3.sv | 33 +++
 rtl/display_arbiter.sv | 109 ++++++++++
 tb/tb_display_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_arbiter_pkg.sv
// Shared definitions for the display arbiter: FSM encoding, source count,
// "no source" marker and the round-robin modulo-3 helper.
package display_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DWELL = 1'b1
   } arb_state_t;

   localparam int          NUM_SRC              = 3;
   localparam logic [1:0]  SRC_NONE             = 2'd3;
   localparam int          DEFAULT_DWELL_CYCLES = 50000000;

   // (idx + step) mod 3, for idx and step in 0..2
   function automatic logic [1:0] rr_next(input logic [1:0] idx, input logic [1:0] step);
      logic [2:0] sum;
      sum = {1'b0, idx} + {1'b0, step};
      if (sum >= 3'd3)
         sum = sum - 3'd3;
      return sum[1:0];
   endfunction

endpackage

// File: rtl/display_arbiter_rr_picker3.sv
// Combinational round-robin picker over three sources.
// The search order is last+1, last+2, then last itself.
module rr_picker3
   import display_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic       valid,
   output logic [1:0] idx
);

   logic [1:0] cand_1;
   logic [1:0] cand_2;

   assign cand_1 = rr_next(last, 2'd1);
   assign cand_2 = rr_next(last, 2'd2);

   always_comb begin
      valid = 1'b0;
      idx   = last;
      if (req[cand_1]) begin
         valid = 1'b1;
         idx   = cand_1;
      end else if (req[cand_2]) begin
         valid = 1'b1;
         idx   = cand_2;
      end else if (req[last]) begin
         valid = 1'b1;
         idx   = last;
      end
   end

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates three display sources: captures one granted value, holds it on the
// seven-segment nibbles for DWELL_CYCLES, then serves the next requester.
module display_arbiter
   import display_arbiter_pkg::*;
#(
   parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES
) (
   input  logic        i_Clk,
   input  logic        reset,
   input  logic [2:0]  i_Req,
   input  logic [15:0] i_Data_0,
   input  logic [15:0] i_Data_1,
   input  logic [15:0] i_Data_2,
   output logic [2:0]  o_Ack,
   output logic [1:0]  o_Src_Id,
   output logic        o_Busy,
   output logic [3:0]  o_Binary_Num_1,
   output logic [3:0]  o_Binary_Num_2,
   output logic [3:0]  o_Binary_Num_3,
   output logic [3:0]  o_Binary_Num_4,
   output logic        o_State
);

   // Handshake: i_Req[k] is a level held by source k until o_Ack[k] pulses for
   // one cycle; the ack pulse means i_Data_k was sampled on that same edge.

   localparam int                CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

   arb_state_t       state;
   arb_state_t       next_state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       last;
   logic             capture;
   logic             pick_valid;
   logic [1:0]       pick_idx;
   logic [15:0]      pick_data;
   logic [15:0]      disp;

   rr_picker3 u_picker (
      .req   (i_Req),
      .last  (last),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      case (pick_idx)
         2'd0:    pick_data = i_Data_0;
         2'd1:    pick_data = i_Data_1;
         default: pick_data = i_Data_2;
      endcase
   end

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               capture    = 1'b1;
               next_state = ST_DWELL;
            end
         end
         ST_DWELL: begin
            if (cnt == CNT_LAST)
               next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // Requests are never latched: only the capture edge looks at i_Req/i_Data.
   always_ff @(posedge i_Clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         last     <= 2'd2;
         o_Ack    <= 3'b000;
         o_Src_Id <= SRC_NONE;
         disp     <= 16'h0000;
      end else begin
         o_Ack <= 3'b000;
         if (capture) begin
            o_Ack    <= 3'b001 << pick_idx;
            o_Src_Id <= pick_idx;
            last     <= pick_idx;
            disp     <= pick_data;
            cnt      <= '0;
         end else if (state == ST_DWELL) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign o_Busy         = (state == ST_DWELL);
   assign o_State        = state;
   assign o_Binary_Num_1 = disp[15:12];
   assign o_Binary_Num_2 = disp[11:8];
   assign o_Binary_Num_3 = disp[7:4];
   assign o_Binary_Num_4 = disp[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with DWELL_CYCLES=4: directed vectors, a cycle-level
// behavioural model with an expected-capture queue, and literal checkpoints.
module tb_display_arbiter;

   localparam int DWELL = 4;

   logic        i_Clk = 1'b0;
   logic        reset;
   logic [2:0]  i_Req;
   logic [15:0] i_Data_0, i_Data_1, i_Data_2;
   logic [2:0]  o_Ack;
   logic [1:0]  o_Src_Id;
   logic        o_Busy;
   logic [3:0]  o_Binary_Num_1, o_Binary_Num_2, o_Binary_Num_3, o_Binary_Num_4;
   logic        o_State;
   logic [15:0] dut_disp;

   int checks = 0;
   int errors = 0;

   display_arbiter #(.DWELL_CYCLES(DWELL)) dut (
      .i_Clk          (i_Clk),
      .reset          (reset),
      .i_Req          (i_Req),
      .i_Data_0       (i_Data_0),
      .i_Data_1       (i_Data_1),
      .i_Data_2       (i_Data_2),
      .o_Ack          (o_Ack),
      .o_Src_Id       (o_Src_Id),
      .o_Busy         (o_Busy),
      .o_Binary_Num_1 (o_Binary_Num_1),
      .o_Binary_Num_2 (o_Binary_Num_2),
      .o_Binary_Num_3 (o_Binary_Num_3),
      .o_Binary_Num_4 (o_Binary_Num_4),
      .o_State        (o_State)
   );

   assign dut_disp = {o_Binary_Num_1, o_Binary_Num_2, o_Binary_Num_3, o_Binary_Num_4};

   // ---------------- clock / reset ----------------
   always #5 i_Clk = ~i_Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_remaining = 0;
   int          m_last      = 2;
   logic [2:0]  m_ack       = 3'b000;
   logic [1:0]  m_src       = 2'd3;
   logic [15:0] m_disp      = 16'h0000;
   logic [17:0] exp_q[$];

   function automatic logic [15:0] src_data(input int k);
      case (k)
         0:       return i_Data_0;
         1:       return i_Data_1;
         default: return i_Data_2;
      endcase
   endfunction

   always @(posedge i_Clk or posedge reset) begin
      if (reset) begin
         m_remaining = 0;
         m_last      = 2;
         m_ack       = 3'b000;
         m_src       = 2'd3;
         m_disp      = 16'h0000;
         exp_q.delete();
      end else if (m_remaining > 0) begin
         m_remaining = m_remaining - 1;
         m_ack       = 3'b000;
      end else begin
         m_ack = 3'b000;
         for (int j = 1; j <= 3; j++) begin
            int k;
            k = (m_last + j) % 3;
            if (m_ack == 3'b000 && i_Req[k]) begin
               m_ack       = 3'b001 << k;
               m_src       = 2'(k);
               m_disp      = src_data(k);
               m_last      = k;
               m_remaining = DWELL;
               exp_q.push_back({2'(k), src_data(k)});
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge i_Clk) begin
      if (reset === 1'b0) begin
         check("model_ack", 32'(o_Ack), 32'(m_ack));
         check("model_src", 32'(o_Src_Id), 32'(m_src));
         check("model_busy", 32'(o_Busy), 32'(m_remaining > 0));
         check("model_disp", 32'(dut_disp), 32'(m_disp));
         if (o_Ack != 3'b000) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_ack", 32'(o_Ack), 32'h0);
            end else begin
               logic [17:0] e;
               e = exp_q.pop_front();
               check("sb_src", 32'(o_Src_Id), 32'(e[17:16]));
               check("sb_data", 32'(dut_disp), 32'(e[15:0]));
            end
         end
      end
   end

   // ---------------- driver / directed sequence ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge i_Clk);
   endtask

   int exp_off[4] = '{1, 6, 11, 16};
   int exp_src[4] = '{0, 1, 2, 0};
   int got_off[4];
   int got_src[4];

   initial begin
      int busy_cnt;
      int fall_ok;
      int n_ack;

      reset    = 1'b1;
      i_Req    = 3'b000;
      i_Data_0 = 16'h0A0A;
      i_Data_1 = 16'h0000;
      i_Data_2 = 16'h0000;
      tick(2);
      check("reset_src", 32'(o_Src_Id), 32'd3);
      check("reset_ack", 32'(o_Ack), 32'd0);
      check("reset_busy", 32'(o_Busy), 32'd0);
      check("reset_disp", 32'(dut_disp), 32'h0);
      check("reset_state", 32'(o_State), 32'd0);
      reset = 1'b0;
      tick(3);
      check("idle_no_ack", 32'(o_Ack), 32'd0);
      check("idle_src_none", 32'(o_Src_Id), 32'd3);

      // single request, then data change and new request during the dwell
      i_Data_1 = 16'hBEEF;
      i_Req    = 3'b010;
      tick(1);
      check("single_ack", 32'(o_Ack), 32'b010);
      check("single_src", 32'(o_Src_Id), 32'd1);
      check("single_disp", 32'(dut_disp), 32'hBEEF);
      check("single_busy", 32'(o_Busy), 32'd1);
      i_Req    = 3'b000;
      i_Data_1 = 16'h1234;
      busy_cnt = 1;
      tick(1);
      if (o_Busy) busy_cnt++;
      check("hold_disp", 32'(dut_disp), 32'hBEEF);
      check("dwell_no_ack", 32'(o_Ack), 32'd0);
      i_Req    = 3'b100;
      i_Data_2 = 16'hCAFE;
      fall_ok  = 0;
      for (int i = 0; i < 10 && fall_ok == 0; i++) begin
         tick(1);
         if (o_Busy) busy_cnt++;
         else fall_ok = 1;
      end
      check("busy_fall_seen", 32'(fall_ok), 32'd1);
      check("busy_len", 32'(busy_cnt), 32'd4);
      check("fall_disp", 32'(dut_disp), 32'hBEEF);
      check("fall_ack", 32'(o_Ack), 32'd0);
      tick(1);
      check("late_ack", 32'(o_Ack), 32'b100);
      check("late_disp", 32'(dut_disp), 32'hCAFE);
      i_Req = 3'b000;
      tick(6);

      // contention: all three held, last granted was 2
      i_Data_0 = 16'h1111;
      i_Data_1 = 16'h2222;
      i_Data_2 = 16'h3333;
      i_Req    = 3'b111;
      n_ack    = 0;
      for (int off = 1; off <= 18; off++) begin
         tick(1);
         if (o_Ack != 3'b000) begin
            if (n_ack < 4) begin
               got_off[n_ack] = off;
               got_src[n_ack] = int'(o_Src_Id);
            end
            n_ack++;
         end
      end
      check("cont_n_ack", 32'(n_ack), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("cont_offset", 32'(got_off[i]), 32'(exp_off[i]));
         check("cont_src", 32'(got_src[i]), 32'(exp_src[i]));
      end

      // abort: dwell counter is at 2 here, request still pending
      #2;
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(o_Busy), 32'd0);
      check("abort_src", 32'(o_Src_Id), 32'd3);
      check("abort_ack", 32'(o_Ack), 32'd0);
      check("abort_disp", 32'(dut_disp), 32'h0);
      i_Req = 3'b000;
      tick(1);
      reset = 1'b0;
      n_ack = 0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         if (o_Ack != 3'b000) n_ack++;
      end
      check("post_reset_no_ack", 32'(n_ack), 32'd0);
      i_Req = 3'b001;
      tick(1);
      check("abort_first_grant", 32'(o_Ack), 32'b001);
      check("abort_first_disp", 32'(dut_disp), 32'h1111);
      i_Req = 3'b000;

      // a request that drops during the dwell is forgotten
      tick(1);
      i_Req = 3'b010;
      tick(1);
      i_Req = 3'b000;
      n_ack = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (o_Ack != 3'b000) n_ack++;
      end
      check("dropped_req_ignored", 32'(n_ack), 32'd0);

      // fairness: last is 0, sources 0 and 1 both held
      i_Data_0 = 16'h5A5A;
      i_Data_1 = 16'hA5A5;
      i_Req    = 3'b011;
      tick(1);
      check("fair_first", 32'(o_Ack), 32'b010);
      tick(5);
      check("fair_second", 32'(o_Ack), 32'b001);
      check("fair_second_disp", 32'(dut_disp), 32'h5A5A);
      tick(5);
      check("fair_third", 32'(o_Ack), 32'b010);
      i_Req = 3'b000;
      tick(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
